// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and defaults for the rPLL lock sequencer.
// State encoding, rPLL dynamic-input defaults and status widths.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_LOCK,
        S_SETTLE,
        S_RUN,
        S_PHASE
    } state_t;

    // Must match PSDA_SEL / DUTYDA_SEL in the Gowin_rPLL wrapper
    localparam logic [3:0] PSDA_DEFAULT   = 4'b0000;
    localparam logic [3:0] DUTYDA_DEFAULT = 4'b1000;

    localparam int RETRY_W = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Output resets low so a stale lock is never seen after rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer with run-time phase/duty stepping.
// Drives RESET/RESET_P/PSDA/DUTYDA and a clean downstream reset.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int         RESET_CYCLES  = 16,
    parameter int         LOCK_TIMEOUT  = 2700000,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         PHASE_SETTLE  = 64,
    parameter logic [3:0] PSDA_INIT     = PSDA_DEFAULT,
    parameter logic [3:0] DUTYDA_INIT   = DUTYDA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               pll_reset_p,
    output logic [3:0]         pll_psda,
    output logic [3:0]         pll_dutyda,
    input  logic               phase_req,
    input  logic [3:0]         phase_val,
    input  logic [3:0]         duty_val,
    output logic               phase_ack,
    output logic               ready,
    output logic               out_rst,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_MAX = max4(RESET_CYCLES, LOCK_TIMEOUT,
                                  SETTLE_CYCLES, PHASE_SETTLE);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] PHASE_LAST  = CW'(PHASE_SETTLE - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          lock_s;
    logic          retry_inc;
    logic          apply;

    logic          pll_reset_d;
    logic          out_rst_d;
    logic          ready_d;
    logic          phase_ack_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State register; the counter restarts on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state || state == S_RUN)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        apply     = 1'b0;
        unique case (state)
            S_RESET: begin
                if (cnt == RESET_LAST)
                    state_n = S_LOCK;
            end
            S_LOCK: begin
                if (lock_s) begin
                    state_n = S_SETTLE;
                end else if (cnt == LOCK_LAST) begin
                    state_n   = S_RESET;
                    retry_inc = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_n   = S_RESET;
                    retry_inc = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                // An ack-cycle request is the one just served
                if (!lock_s) begin
                    state_n   = S_RESET;
                    retry_inc = 1'b1;
                end else if (phase_req && !phase_ack) begin
                    state_n = S_PHASE;
                    apply   = 1'b1;
                end
            end
            S_PHASE: begin
                if (!lock_s) begin
                    state_n   = S_RESET;
                    retry_inc = 1'b1;
                end else if (cnt == PHASE_LAST) begin
                    state_n = S_RUN;
                end
            end
            default: begin
                state_n = S_RESET;
            end
        endcase
    end

    // Decoded from the next state so registered outputs align with it
    always_comb begin
        pll_reset_d = (state_n == S_RESET);
        out_rst_d   = !(state_n == S_RUN || state_n == S_PHASE);
        ready_d     = (state_n == S_RUN);
        phase_ack_d = (state == S_PHASE) && (state_n == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_reset   <= 1'b1;
            pll_reset_p <= 1'b1;
            out_rst     <= 1'b1;
            ready       <= 1'b0;
            phase_ack   <= 1'b0;
        end else begin
            pll_reset   <= pll_reset_d;
            pll_reset_p <= pll_reset_d;
            out_rst     <= out_rst_d;
            ready       <= ready_d;
            phase_ack   <= phase_ack_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_psda   <= PSDA_INIT;
            pll_dutyda <= DUTYDA_INIT;
        end else if (apply) begin
            pll_psda   <= phase_val;
            pll_dutyda <= duty_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retry_count <= '0;
        else if (retry_inc && retry_count != RETRY_MAX)
            retry_count <= retry_count + RETRY_W'(1);
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer.
// Expected timings are derived from the sequencing rules directly.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       phase_req = 1'b0;
    logic [3:0] phase_val = 4'h0;
    logic [3:0] duty_val = 4'h0;
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       phase_ack;
    logic       ready;
    logic       out_rst;
    logic [7:0] retry_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .PHASE_SETTLE  (PS),
        .PSDA_INIT     (4'b0000),
        .DUTYDA_INIT   (4'b1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .phase_req   (phase_req),
        .phase_val   (phase_val),
        .duty_val    (duty_val),
        .phase_ack   (phase_ack),
        .ready       (ready),
        .out_rst     (out_rst),
        .retry_count (retry_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle after rst release
    task automatic do_reset();
        rst       = 1'b1;
        pll_lock  = 1'b0;
        phase_req = 1'b0;
        phase_val = 4'h0;
        duty_val  = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Lock at cycle 4 -> lock_s at 6 -> settle 7..14 -> run at 15
    task automatic bring_up();
        do_reset();
        repeat (4) tick();
        pll_lock = 1'b1;
        repeat (11) tick();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL bring_up: ready=%b required 1", ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({pll_reset, pll_reset_p, out_rst, ready, phase_ack} !== 5'b11100) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 11100",
                     {pll_reset, pll_reset_p, out_rst, ready, phase_ack});
        end
        n_cmp++;
        if (retry_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_retry: got %0d required 0", retry_count);
        end
        n_cmp++;
        if (pll_psda !== 4'h0 || pll_dutyda !== 4'h8) begin
            n_err++;
            $display("FAIL reset_psda: got %h/%h required 0/8",
                     pll_psda, pll_dutyda);
        end
    endtask

    task automatic test_cold_start(input int d);
        int errs;
        logic exp_rst;
        logic exp_rdy;
        errs = 0;
        do_reset();
        for (int c = 0; c <= d + 3 + SC + 3; c++) begin
            exp_rst = (c < RC);
            exp_rdy = (c >= d + 3 + SC);
            n_cmp++;
            if ({pll_reset, pll_reset_p, ready, out_rst, retry_count}
                !== {exp_rst, exp_rst, exp_rdy, !exp_rdy, 8'd0}) begin
                n_err++;
                if (errs++ < 5)
                    $display("FAIL cold_start d=%0d c=%0d: rst/rstp/rdy/orst/retry=%b%b%b%b/%0d required %b%b%b%b/0",
                             d, c, pll_reset, pll_reset_p, ready, out_rst,
                             retry_count, exp_rst, exp_rst, exp_rdy, !exp_rdy);
            end
            if (c == d) pll_lock = 1'b1;
            tick();
        end
    endtask

    task automatic test_timeout();
        int errs;
        int per;
        logic exp_rst;
        int exp_retry;
        errs = 0;
        per  = LT + RC;
        do_reset();
        for (int c = 0; c < 300 * per + 40; c++) begin
            exp_rst   = (c < RC) || (((c - RC) % per) >= LT);
            exp_retry = (c / per > 255) ? 255 : c / per;
            n_cmp++;
            if (pll_reset !== exp_rst || retry_count !== 8'(exp_retry)
                || ready !== 1'b0 || out_rst !== 1'b1) begin
                n_err++;
                if (errs++ < 5)
                    $display("FAIL timeout c=%0d: rst=%b retry=%0d rdy=%b orst=%b required rst=%b retry=%0d rdy=0 orst=1",
                             c, pll_reset, retry_count, ready, out_rst,
                             exp_rst, exp_retry);
            end
            tick();
        end
        n_cmp++;
        if (retry_count !== 8'd255) begin
            n_err++;
            $display("FAIL timeout_saturate: got %0d required 255", retry_count);
        end
    endtask

    task automatic test_glitch();
        int errs;
        logic exp_rst;
        logic exp_rdy;
        logic [7:0] exp_retry;
        errs = 0;
        do_reset();
        for (int c = 0; c <= 27; c++) begin
            exp_rst   = (c < RC) || (c >= 12 && c < 12 + RC);
            exp_rdy   = (c >= 25);
            exp_retry = (c >= 12) ? 8'd1 : 8'd0;
            n_cmp++;
            if (pll_reset !== exp_rst || ready !== exp_rdy
                || retry_count !== exp_retry) begin
                n_err++;
                if (errs++ < 5)
                    $display("FAIL glitch c=%0d: rst=%b rdy=%b retry=%0d required %b %b %0d",
                             c, pll_reset, ready, retry_count,
                             exp_rst, exp_rdy, exp_retry);
            end
            if (c == 4)  pll_lock = 1'b1;
            if (c == 9)  pll_lock = 1'b0;
            if (c == 11) pll_lock = 1'b1;
            tick();
        end
    endtask

    task automatic test_phase(input int iters);
        logic [3:0] m_psda;
        logic [3:0] m_duty;
        logic [3:0] pv;
        logic [3:0] dv;
        int gap;
        bring_up();
        m_psda = 4'h0;
        m_duty = 4'h8;
        for (int it = 0; it < iters; it++) begin
            gap = $urandom_range(1, 3);
            repeat (gap) begin
                n_cmp++;
                if (ready !== 1'b1 || pll_psda !== m_psda || pll_dutyda !== m_duty) begin
                    n_err++;
                    $display("FAIL phase_idle it=%0d: rdy=%b psda=%h duty=%h required 1 %h %h",
                             it, ready, pll_psda, pll_dutyda, m_psda, m_duty);
                end
                tick();
            end
            pv = (it == 0) ? 4'h5 : 4'($urandom);
            dv = (it == 0) ? 4'h6 : 4'($urandom);
            phase_val = pv;
            duty_val  = dv;
            phase_req = 1'b1;
            m_psda = pv;
            m_duty = dv;
            for (int k = 1; k <= PS + 1; k++) begin
                tick();
                n_cmp++;
                if (pll_psda !== m_psda || pll_dutyda !== m_duty
                    || ready !== (k == PS + 1) || phase_ack !== (k == PS + 1)
                    || out_rst !== 1'b0) begin
                    n_err++;
                    $display("FAIL phase_seq it=%0d k=%0d: psda=%h duty=%h rdy=%b ack=%b orst=%b required %h %h %b %b 0",
                             it, k, pll_psda, pll_dutyda, ready, phase_ack,
                             out_rst, m_psda, m_duty, k == PS + 1, k == PS + 1);
                end
            end
            tick();
            phase_req = 1'b0;
            n_cmp++;
            if (phase_ack !== 1'b0 || ready !== 1'b1) begin
                n_err++;
                $display("FAIL phase_no_resample it=%0d: ack=%b rdy=%b required 0 1",
                         it, phase_ack, ready);
            end
        end
    endtask

    task automatic test_drop_with_req();
        int acks;
        int drop_at;
        bring_up();
        tick();
        pll_lock  = 1'b0;
        phase_val = 4'hC;
        duty_val  = 4'h2;
        phase_req = 1'b1;
        acks    = 0;
        drop_at = -1;
        for (int j = 0; j <= 60; j++) begin
            if (j == 2) begin
                n_cmp++;
                if (out_rst !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_orst_early: got %b required 0", out_rst);
                end
            end
            if (j == 3) begin
                n_cmp++;
                if (out_rst !== 1'b1 || ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_orst: orst=%b rdy=%b required 1 0",
                             out_rst, ready);
                end
            end
            if (phase_ack === 1'b1) begin
                acks++;
                drop_at = j + 1;
            end
            if (j == drop_at) phase_req = 1'b0;
            if (j == 6) pll_lock = 1'b1;
            tick();
        end
        n_cmp++;
        if (acks !== 1) begin
            n_err++;
            $display("FAIL drop_acks: got %0d required 1", acks);
        end
        n_cmp++;
        if (pll_psda !== 4'hC || pll_dutyda !== 4'h2 || retry_count !== 8'd1
            || ready !== 1'b1) begin
            n_err++;
            $display("FAIL drop_final: psda=%h duty=%h retry=%0d rdy=%b required c 2 1 1",
                     pll_psda, pll_dutyda, retry_count, ready);
        end
    endtask

    task automatic test_rst_mid_phase();
        bring_up();
        phase_val = 4'hA;
        duty_val  = 4'h3;
        phase_req = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_reset, pll_reset_p, out_rst, ready, phase_ack} !== 5'b11100
            || pll_psda !== 4'h0 || pll_dutyda !== 4'h8 || retry_count !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid_phase: flags=%b psda=%h duty=%h retry=%0d required 11100 0 8 0",
                     {pll_reset, pll_reset_p, out_rst, ready, phase_ack},
                     pll_psda, pll_dutyda, retry_count);
        end
        phase_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_start(10);
        test_cold_start(int'($urandom_range(4, 30)));
        test_timeout();
        test_glitch();
        test_phase(6);
        test_drop_with_req();
        test_rst_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
